// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file: FSM states, the
// hard-wired zero register and the address-validity helper.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

  localparam int unsigned REG_ZERO = 32'd0;

  // Register $0 and anything beyond the implemented range are not real storage.
  function automatic logic addr_valid(input int unsigned addr, input int unsigned num_regs);
    return (addr != REG_ZERO) && (addr < num_regs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for multi-cycle producers, with two combinational
// lookup ports. An alloc on the same edge as a write to the same register wins.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              upd_en_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic              alloc_en_i,
  input  logic [ADDR_W-1:0] alloc_addr_i,
  input  logic [ADDR_W-1:0] lk1_addr_i,
  input  logic [ADDR_W-1:0] lk2_addr_i,
  output logic              lk1_pending_o,
  output logic              lk2_pending_o
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  // Next-state: write clears first, alloc then sets, so alloc has priority.
  always_comb begin
    pending_d = pending_q;
    if (upd_en_i) begin
      if (wr_en_i && addr_valid(32'(wr_addr_i), NUM_REGS)) begin
        pending_d[wr_addr_i[IDX_W-1:0]] = 1'b0;
      end else begin
        pending_d = pending_d;
      end
      if (alloc_en_i && addr_valid(32'(alloc_addr_i), NUM_REGS)) begin
        pending_d[alloc_addr_i[IDX_W-1:0]] = 1'b1;
      end else begin
        pending_d = pending_d;
      end
    end else begin
      pending_d = pending_q;
    end
  end

  // Pending bit storage, dropped on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= {NUM_REGS{1'b0}};
    end else begin
      pending_q <= pending_d;
    end
  end

  // Lookup ports; invalid addresses never report pending.
  always_comb begin
    if (addr_valid(32'(lk1_addr_i), NUM_REGS)) begin
      lk1_pending_o = pending_q[lk1_addr_i[IDX_W-1:0]];
    end else begin
      lk1_pending_o = 1'b0;
    end
    if (addr_valid(32'(lk2_addr_i), NUM_REGS)) begin
      lk2_pending_o = pending_q[lk2_addr_i[IDX_W-1:0]];
    end else begin
      lk2_pending_o = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_param.sv
// MIPS-style register file: two combinational read ports with optional write
// bypass, a post-reset clear sweep, and a pending scoreboard beside storage.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_addr,
  output logic              rd1_pending,
  output logic              rd2_pending,
  output logic              ready
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  rf_state_e         state_q, state_d;
  logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic              is_ready_s;
  logic              wr_ok_s;
  logic              sb_p1_s, sb_p2_s;

  assign is_ready_s = (state_q == READY);
  assign wr_ok_s    = is_ready_s && regwrite && addr_valid(32'(wa), NUM_REGS);
  assign ready      = ready_q;

  // Clear sequencer next-state: sweep $1..$NUM_REGS-1, then hold READY.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + IDX_W'(1);
        if (clr_idx_q == IDX_W'(NUM_REGS - 1)) begin
          state_d = READY;
        end else begin
          state_d = CLEAR;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
    ready_d = (state_d == READY);
  end

  // Sequencer state, clear index and registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_idx_q <= IDX_W'(1);
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
    end
  end

  // Storage array; not reset directly, the clear sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[clr_idx_q] <= {DATA_W{1'b0}};
    end else if (wr_ok_s) begin
      mem_q[wa[IDX_W-1:0]] <= wd;
    end else begin
      mem_q <= mem_q;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .upd_en_i     (is_ready_s),
    .wr_en_i      (regwrite),
    .wr_addr_i    (wa),
    .alloc_en_i   (alloc_en),
    .alloc_addr_i (alloc_addr),
    .lk1_addr_i   (ra1),
    .lk2_addr_i   (ra2),
    .lk1_pending_o(sb_p1_s),
    .lk2_pending_o(sb_p2_s)
  );

  // Read port 1: masked in CLEAR, optional forwarding of the in-flight write.
  always_comb begin
    rd1         = {DATA_W{1'b0}};
    rd1_pending = 1'b0;
    if (is_ready_s && addr_valid(32'(ra1), NUM_REGS)) begin
      if ((BYPASS == 1) && wr_ok_s && (wa == ra1)) begin
        rd1         = wd;
        rd1_pending = (alloc_en && (alloc_addr == ra1)) ? sb_p1_s : 1'b0;
      end else begin
        rd1         = mem_q[ra1[IDX_W-1:0]];
        rd1_pending = sb_p1_s;
      end
    end else begin
      rd1         = {DATA_W{1'b0}};
      rd1_pending = 1'b0;
    end
  end

  // Read port 2: same behaviour as port 1.
  always_comb begin
    rd2         = {DATA_W{1'b0}};
    rd2_pending = 1'b0;
    if (is_ready_s && addr_valid(32'(ra2), NUM_REGS)) begin
      if ((BYPASS == 1) && wr_ok_s && (wa == ra2)) begin
        rd2         = wd;
        rd2_pending = (alloc_en && (alloc_addr == ra2)) ? sb_p2_s : 1'b0;
      end else begin
        rd2         = mem_q[ra2[IDX_W-1:0]];
        rd2_pending = sb_p2_s;
      end
    end else begin
      rd2         = {DATA_W{1'b0}};
      rd2_pending = 1'b0;
    end
  end

endmodule
